// File: rtl/stage_fetch.sv
// stage_fetch: instruction fetch stage driving a Wishbone-style instruction bus.
// Define FETCH_SKID_EN to add a one-entry skid buffer for one fetch per cycle.
module stage_fetch #(
   parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        is_br_j_taken_i,
   input  logic [31:0] br_j_addr_i,
   output logic [31:0] iwbm_addr_o,
   output logic        iwbm_cyc_o,
   output logic        iwbm_stb_o,
   input  logic [31:0] iwbm_dat_i,
   input  logic        iwbm_ack_i,
   input  logic        iwbm_err_i,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   output logic        valid_o,
   output logic        e_inst_access_fault_o
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      HOLD,
      FLUSH,
      FAULT
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pco_q, pco_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;

   logic        stb;
   logic        ack;
   logic        err;
   logic        xfer;
   logic        redir;
   logic [31:0] pc_inc;
   logic [31:0] rsp_inst;

`ifdef FETCH_SKID_EN
   logic [31:0] sk_inst_q, sk_inst_d;
   logic [31:0] sk_pc_q, sk_pc_d;
   logic        sk_v_q, sk_v_d;
   logic        sk_f_q, sk_f_d;
`endif

   assign stb      = (state_q == REQ) || (state_q == FLUSH);
   assign err      = stb & iwbm_err_i;
   assign ack      = stb & iwbm_ack_i & ~iwbm_err_i;
   assign xfer     = valid_q & ~stall_i;
   assign redir    = is_br_j_taken_i;
   assign pc_inc   = pc_q + 32'd4;
   assign rsp_inst = err ? NOP : iwbm_dat_i;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      // FLUSH keeps presenting the abandoned address until it terminates
      addr_d  = (state_q == FLUSH) ? addr_q : pc_q;
      inst_d  = inst_q;
      pco_d   = pco_q;
      valid_d = valid_q;
      fault_d = fault_q;
`ifdef FETCH_SKID_EN
      sk_inst_d = sk_inst_q;
      sk_pc_d   = sk_pc_q;
      sk_v_d    = sk_v_q;
      sk_f_d    = sk_f_q;
`endif

      if (xfer) begin
`ifdef FETCH_SKID_EN
         if (sk_v_q) begin
            inst_d  = sk_inst_q;
            pco_d   = sk_pc_q;
            fault_d = sk_f_q;
            sk_v_d  = 1'b0;
         end else begin
            valid_d = 1'b0;
         end
`else
         valid_d = 1'b0;
`endif
      end

      if (redir) begin
         valid_d = 1'b0;
         fault_d = 1'b0;
         pc_d    = br_j_addr_i;
`ifdef FETCH_SKID_EN
         sk_v_d  = 1'b0;
`endif
         if (stb && !(iwbm_ack_i || iwbm_err_i)) begin
            state_d = FLUSH;
         end else begin
            state_d = REQ;
         end
      end else begin
         unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
               if (ack || err) begin
`ifdef FETCH_SKID_EN
                  if (valid_q && stall_i) begin
                     sk_inst_d = rsp_inst;
                     sk_pc_d   = pc_q;
                     sk_f_d    = err;
                     sk_v_d    = 1'b1;
                  end else
`endif
                  begin
                     inst_d  = rsp_inst;
                     pco_d   = pc_q;
                     valid_d = 1'b1;
                     fault_d = err;
                  end
                  if (err) begin
                     state_d = FAULT;
                  end else begin
                     pc_d = pc_inc;
`ifdef FETCH_SKID_EN
                     state_d = (valid_q && stall_i) ? HOLD : REQ;
`else
                     state_d = HOLD;
`endif
                  end
               end
            end
            HOLD: begin
               if (xfer) begin
                  state_d = REQ;
               end
            end
            FLUSH: begin
               if (ack || err) begin
                  state_d = REQ;
               end
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         pc_q    <= RESET_ADDR;
         addr_q  <= RESET_ADDR;
         inst_q  <= NOP;
         pco_q   <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         inst_q  <= inst_d;
         pco_q   <= pco_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

`ifdef FETCH_SKID_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sk_inst_q <= NOP;
         sk_pc_q   <= '0;
         sk_v_q    <= 1'b0;
         sk_f_q    <= 1'b0;
      end else begin
         sk_inst_q <= sk_inst_d;
         sk_pc_q   <= sk_pc_d;
         sk_v_q    <= sk_v_d;
         sk_f_q    <= sk_f_d;
      end
   end
`endif

   assign iwbm_stb_o            = stb;
   assign iwbm_cyc_o            = stb;
   assign iwbm_addr_o           = (state_q == FLUSH) ? addr_q : pc_q;
   assign inst_o                = inst_q;
   assign pc_o                  = pco_q;
   assign valid_o               = valid_q;
   assign e_inst_access_fault_o = fault_q;

`ifndef SYNTHESIS
   a_addr_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (stb && !iwbm_ack_i && !iwbm_err_i) |=> (iwbm_addr_o == $past(iwbm_addr_o)));

   a_out_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (valid_q && stall_i && !redir) |=>
      (valid_q && inst_q == $past(inst_q) && pco_q == $past(pco_q)));
`endif

endmodule
